rr_arbiter_4: RTL

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4.sv | 98 +++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time and a
// mandatory one-cycle idle gap between consecutive grants.
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  logic [1:0] state;
  logic [1:0] last;
  logic [7:0] hold;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       hold_hit;
  logic       exit_grant;
  logic       exit_timeout;

  // Search starts just after the previous grantee so every requester gets a turn.
  always_comb begin
    winner = last;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign hold_hit     = (hold == HOLD_LIM);
  assign exit_grant   = rel || !en || !req[gnt_id] || hold_hit;
  assign exit_timeout = !rel && en && req[gnt_id] && hold_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      gnt_id    <= 2'b00;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold      <= 8'd0;
      last      <= 2'd3;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (en && (req != 4'b0000)) begin
            state     <= GRANT;
            gnt_id    <= winner;
            gnt       <= 4'b0001 << winner;
            gnt_valid <= 1'b1;
            hold      <= 8'd1;
          end else begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          // gnt_id is deliberately kept through the gap as the most recent grantee.
          if (exit_grant) begin
            state     <= GAP;
            last      <= gnt_id;
            hold      <= 8'd0;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            timeout   <= exit_timeout;
          end else if (hold != 8'hFF) begin
            hold <= hold + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 4'b0000;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
